// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid pipeline register with flush, hold, retire history and transfer counter.
module pipe_stage_reg #(
    parameter int WIDTH      = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        flush,
    input  logic                        hold,
    output logic [1:0]                  occupancy,
    output logic [HIST_DEPTH*WIDTH-1:0] hist_data,
    output logic [HIST_DEPTH-1:0]       hist_valid,
    output logic [15:0]                 xfer_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] m, s, m_nx, s_nx;
    logic [WIDTH-1:0] hist_q [HIST_DEPTH];
    logic             acc, xfer;
    assign in_ready  = (state != TWO) && !hold && !flush;
    assign out_valid = (state != EMPTY) && !hold && !flush;
    assign out_data  = m;
    assign occupancy = state;
    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    always_comb begin
        state_nx = state;
        m_nx     = m;
        s_nx     = s;
        if (flush) begin
            state_nx = EMPTY;
            m_nx     = '0;
            s_nx     = '0;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_nx = ONE;
                    m_nx     = in_data;
                end
                ONE: if (acc && !xfer) begin
                    state_nx = TWO;
                    s_nx     = in_data;
                end else if (xfer && !acc) begin
                    state_nx = EMPTY;
                    m_nx     = '0;
                end else if (acc && xfer) begin
                    m_nx     = in_data;
                end
                TWO: if (xfer) begin
                    state_nx = ONE;
                    m_nx     = s;
                    s_nx     = '0;
                end
                default: begin
                    state_nx = EMPTY;
                    m_nx     = '0;
                    s_nx     = '0;
                end
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
            m     <= '0;
            s     <= '0;
        end else begin
            state <= state_nx;
            m     <= m_nx;
            s     <= s_nx;
        end
    end
    // xfer is already gated by hold and flush, so history only moves on real retirements
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
            hist_valid <= '0;
            xfer_count <= '0;
        end else if (xfer) begin
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                hist_q[k]     <= hist_q[k-1];
                hist_valid[k] <= hist_valid[k-1];
            end
            hist_q[0]     <= m;
            hist_valid[0] <= 1'b1;
            xfer_count    <= xfer_count + 16'd1;
        end
    end
    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
        assign hist_data[g*WIDTH +: WIDTH] = hist_q[g];
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scenario tasks plus a scoreboard monitor checking FIFO order, history and transfer count.
module tb_pipe_stage_reg;
    localparam int W = 32;
    logic          CLK = 1'b0;
    logic          RST, in_valid, in_ready, out_valid, out_ready, flush, hold;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    occupancy;
    logic [2*W-1:0] hist_data;
    logic [1:0]    hist_valid;
    logic [15:0]   xfer_count;
    int            n_pass = 0;
    int            n_total = 0;
    logic [W-1:0]  q[$];
    logic [W-1:0]  exp_h0, exp_h1, head;
    logic [15:0]   exp_cnt;

    pipe_stage_reg #(.WIDTH(W), .HIST_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
        .hold(hold), .occupancy(occupancy), .hist_data(hist_data), .hist_valid(hist_valid),
        .xfer_count(xfer_count)
    );

    always #5 CLK = ~CLK;

    // Inputs change just after posedge, so the falling edge shows what the next rising edge will do.
    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            exp_h0  = '0;
            exp_h1  = '0;
            exp_cnt = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL sb_order: unexpected transfer of %h, want no transfer", out_data);
                    head = 'x;
                end else begin
                    head = q.pop_front();
                    if (out_data !== head) $display("FAIL sb_order: got %h want %h", out_data, head);
                    else n_pass++;
                end
                exp_h1  = exp_h0;
                exp_h0  = head;
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1; in_valid = 0; out_ready = 0; flush = 0; hold = 0; in_data = '0;
        tick(); tick();
        RST = 0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
        n_total++; if (hist_valid !== 2'b00 || hist_data !== '0) $display("FAIL reset_hist: got %b/%h want 0/0", hist_valid, hist_data); else n_pass++;
        n_total++; if (xfer_count !== 16'd0) $display("FAIL reset_cnt: got %h want 0", xfer_count); else n_pass++;
    endtask

    task automatic test_stream();
        in_valid = 1; out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            in_data = W'(i);
            tick();
            n_total++;
            if (out_data !== W'(i) || out_valid !== 1'b1 || occupancy !== 2'd1)
                $display("FAIL stream_%0d: got data=%h valid=%b occ=%0d want %h/1/1", i, out_data, out_valid, occupancy, i);
            else n_pass++;
        end
        in_valid = 0;
        tick();
        n_total++; if (xfer_count !== 16'd4) $display("FAIL stream_cnt: got %0d want 4", xfer_count); else n_pass++;
        n_total++; if (hist_data !== {32'd3, 32'd4}) $display("FAIL stream_hist: got %h want 0000000300000004", hist_data); else n_pass++;
        n_total++; if (occupancy !== 2'd0 || out_data !== '0) $display("FAIL stream_drain: got occ=%0d data=%h want 0/0", occupancy, out_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        n_total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) $display("FAIL bp_full: got occ=%0d in_ready=%b want 2/0", occupancy, in_ready); else n_pass++;
        in_data = 32'hC;
        tick();
        n_total++; if (occupancy !== 2'd2 || out_data !== 32'hA) $display("FAIL bp_stall: got occ=%0d data=%h want 2/a", occupancy, out_data); else n_pass++;
        out_ready = 1;
        tick();
        n_total++; if (out_data !== 32'hB || occupancy !== 2'd1) $display("FAIL bp_b: got data=%h occ=%0d want b/1", out_data, occupancy); else n_pass++;
        tick();
        in_valid = 0;
        n_total++; if (out_data !== 32'hC || occupancy !== 2'd1) $display("FAIL bp_c: got data=%h occ=%0d want c/1", out_data, occupancy); else n_pass++;
        tick();
        n_total++; if (q.size() != 0 || xfer_count !== 16'd7) $display("FAIL bp_done: got queue=%0d cnt=%0d want 0/7", q.size(), xfer_count); else n_pass++;
    endtask

    task automatic test_flush();
        logic [15:0]    c;
        logic [2*W-1:0] h;
        out_ready = 0; in_valid = 1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        c = exp_cnt;
        h = {exp_h1, exp_h0};
        flush = 1; out_ready = 1; in_data = 32'hD;
        #1;
        n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL flush_gate: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); else n_pass++;
        tick();
        flush = 0; in_valid = 0;
        n_total++; if (occupancy !== 2'd0 || out_data !== '0) $display("FAIL flush_empty: got occ=%0d data=%h want 0/0", occupancy, out_data); else n_pass++;
        n_total++; if (xfer_count !== c || hist_data !== h) $display("FAIL flush_keep: got cnt=%h hist=%h want %h/%h", xfer_count, hist_data, c, h); else n_pass++;
        tick();
        n_total++; if (xfer_count !== c) $display("FAIL flush_after: got cnt=%h want %h", xfer_count, c); else n_pass++;
    endtask

    task automatic test_hold();
        logic [15:0] c;
        out_ready = 0; in_valid = 1; in_data = 32'h5;
        tick();
        c = exp_cnt;
        hold = 1; in_valid = 1; out_ready = 1; in_data = 32'h6;
        #1;
        n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL hold_gate: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_total++; if (occupancy !== 2'd1 || out_data !== 32'h5 || xfer_count !== c) $display("FAIL hold_freeze: got occ=%0d data=%h cnt=%h want 1/5/%h", occupancy, out_data, xfer_count, c); else n_pass++;
        hold = 0; in_valid = 0;
        tick();
        n_total++; if (xfer_count !== c + 16'd1 || hist_data[W-1:0] !== 32'h5 || occupancy !== 2'd0) $display("FAIL hold_release: got cnt=%h hist0=%h occ=%0d want %h/5/0", xfer_count, hist_data[W-1:0], occupancy, c + 16'd1); else n_pass++;
    endtask

    task automatic test_wrap();
        RST = 1;
        tick();
        RST = 0; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 65534; i++) begin
            in_data = W'(i);
            tick();
        end
        in_valid = 0;
        tick();
        n_total++; if (xfer_count !== 16'hFFFE) $display("FAIL wrap_pre: got %h want fffe", xfer_count); else n_pass++;
        in_valid = 1; in_data = 32'h77;
        tick();
        in_valid = 0;
        tick();
        n_total++; if (xfer_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", xfer_count); else n_pass++;
        in_valid = 1; in_data = 32'h78;
        tick();
        in_valid = 0;
        tick();
        n_total++; if (xfer_count !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", xfer_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        n_total++; if (occupancy !== 2'd2 || hist_valid !== 2'b11) $display("FAIL rmid_pre: got occ=%0d hv=%b want 2/11", occupancy, hist_valid); else n_pass++;
        RST = 1; out_ready = 1;
        tick();
        RST = 0; in_valid = 0; out_ready = 0;
        #1;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) $display("FAIL rmid_out: got rdy=%b vld=%b data=%h occ=%0d want 1/0/0/0", in_ready, out_valid, out_data, occupancy); else n_pass++;
        n_total++; if (hist_valid !== 2'b00 || xfer_count !== 16'd0 || hist_data !== '0) $display("FAIL rmid_hist: got hv=%b cnt=%h hist=%h want 0/0/0", hist_valid, xfer_count, hist_data); else n_pass++;
    endtask

    initial begin
        RST = 1; in_valid = 0; out_ready = 0; flush = 0; hold = 0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold();
        test_wrap();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
